// File: rtl/handshake_scheduler_if.sv
// rtl/handshake_scheduler_if.sv - request/grant and start/done signals of the handshake scheduler
interface handshake_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic [NUM_REQ-1:0] complete;
  logic               timeout;
  logic               hs_start;
  logic               hs_done;

  // Scheduler side: owns grants and drives the channel start pulse
  modport master (
    input  req,
    input  hs_done,
    output grant,
    output grant_id,
    output busy,
    output complete,
    output timeout,
    output hs_start
  );

  // Requesters and handshake channel side
  modport slave (
    output req,
    output hs_done,
    input  grant,
    input  grant_id,
    input  busy,
    input  complete,
    input  timeout,
    input  hs_start
  );
endinterface

// File: rtl/handshake_scheduler.sv
// rtl/handshake_scheduler.sv - round-robin scheduler for one start/done channel; watchdog via HS_SCHED_TIMEOUT_EN
module handshake_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  handshake_scheduler_if.master hs
);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] complete_q, complete_d;
  logic               busy_q, busy_d;
  logic               hs_start_q, hs_start_d;
  logic               timeout_q, timeout_d;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    next_ptr;
  logic               wd_expired;
  logic               abort;

  // Winner: first pending request at or above rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!win_found && hs.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef HS_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog counts cycles spent in the current wait state; any state change restarts it
  always_comb begin
    wd_cnt_d = '0;
    if ((state_q == WAIT_HI || state_q == WAIT_LO) && state_d == state_q)
      wd_cnt_d = wd_cnt_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end

  assign wd_expired = (state_q == WAIT_HI || state_q == WAIT_LO) &&
                      (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expired         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: requests are only looked at in IDLE; a normal done edge wins over an expiring watchdog
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE:    if (win_found) state_d = START;
      START:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (hs.hs_done)      state_d = WAIT_LO;
        else if (wd_expired) begin state_d = IDLE; abort = 1'b1; end
      end
      WAIT_LO: begin
        if (!hs.hs_done)     state_d = DONE;
        else if (wd_expired) begin state_d = IDLE; abort = 1'b1; end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values derived from the upcoming state so every output is a flop
  always_comb begin
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    complete_d = '0;
    timeout_d  = abort;
    busy_d     = (state_d != IDLE);
    hs_start_d = (state_d == START);
    if (state_d == IDLE) begin
      grant_d    = '0;
      grant_id_d = '0;
    end else if (state_q == IDLE) begin
      grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
      grant_id_d = win_id;
    end
    if (state_d == DONE) complete_d = grant_q;
    if (state_q == DONE || abort) rr_ptr_d = next_ptr;
  end

  // Output and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      complete_q <= '0;
      busy_q     <= 1'b0;
      hs_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
      hs_start_q <= hs_start_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hs.grant    = grant_q;
  assign hs.grant_id = grant_id_q;
  assign hs.busy     = busy_q;
  assign hs.complete = complete_q;
  assign hs.timeout  = timeout_q;
  assign hs.hs_start = hs_start_q;

endmodule
